decoder_rr_arbiter: RTL and testbench
=====================================

Name: decoder_rr_arbiter

Overview:
- 4-requester round-robin arbiter that drives the team's 2-to-4 enabled decoder.
- Produces the encoded select (A1:A0) and enable (EN) for the decoder, plus a registered one-hot grant vector.
- Sits between up to four requesters and a shared resource whose strobes come from the decoder outputs Y0..Y3.
- Guarantees break-before-make: one cycle with EN=0 between any two grants.

Parameters:
- HOLD_MAX, 8: max consecutive GRANT cycles for one owner while another requester is pending (only with ARB_TIMEOUT_EN); legal range 1..15.
- CNT_W, 4: width of the hold counter; must satisfy 2^CNT_W > HOLD_MAX.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  4  request per requester; bit i = requester i; level-sensitive.
- sel  out  2  encoded owner index to the decoder; sel[1]=A1, sel[0]=A0.
- sel_en  out  1  decoder enable EN; high only in GRANT.
- gnt  out  4  one-hot grant; equals the decoder output pattern when sel_en=1, else 0.
- busy  out  1  high while in GRANT.

Behaviour:
- Reset (rst_n=0, async, immediate):
  - State IDLE.
  - sel=2'b00, sel_en=0, gnt=4'b0000, busy=0.
  - Priority pointer ptr=0, hold_cnt=0.
  - Reset mid-grant drops gnt and sel_en in the same instant, without waiting for clk.
- All outputs are registered: 1-cycle latency from req sampled at edge t to grant visible after edge t.
- State IDLE (sel_en=0, gnt=0, busy=0, sel holds its last value):
  - At each edge, if req!=0: pick the first set bit scanning ptr, ptr+1, ... mod 4.
  - Then go to GRANT with sel=idx, sel_en=1, gnt=1<<idx, busy=1, hold_cnt=0, ptr=(idx+1) mod 4.
  - If req==0, stay in IDLE; ptr unchanged.
- State GRANT: owner = sel. Define others = |(req & ~gnt). At each edge:
  - req[sel]==0 -> IDLE (release).
  - ARB_TIMEOUT_EN defined, others=1 and hold_cnt==HOLD_MAX-1 -> IDLE (preempt).
  - Otherwise stay in GRANT. hold_cnt increments while others=1 (saturates at HOLD_MAX-1) and clears to 0 while others=0.
- The IDLE cycle after every GRANT is mandatory, even if requests are pending. Minimum grant-to-grant spacing is 1 dead cycle.
- Simultaneous events:
  - Owner drops req in the same cycle as a timeout -> release; the outcome is identical.
  - New requests arriving during GRANT are only considered at the next IDLE arbitration.
- ptr wraps 3 -> 0.
- A requester granted at index i has the lowest priority at the next arbitration.
- Fairness: under full contention (req=4'b1111), grant order is 0,1,2,3,0,...
- Invariants:
  - gnt is always 0 or one-hot.
  - gnt == (sel_en ? 1<<sel : 0).
  - busy == sel_en.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined: preemption via hold_cnt as above. The owner holds at most HOLD_MAX cycles while another requester is pending.
- Not defined:
  - hold_cnt logic is absent; HOLD_MAX and CNT_W are ignored.
  - The owner keeps the grant until it drops req (no preemption).
  - All other behaviour is identical.

Test Plan:
- Reset: assert rst_n=0 between edges while in GRANT with gnt=0100 -> gnt=0000, sel_en=0, busy=0 immediately. After release, req=0001 -> one edge later gnt=0001, sel=00, sel_en=1.
- Round-robin: req=1010 held, owner drops after 2 cycles each. Expect gnt 0010, 0010, 0000, 1000, 1000, 0000, 0010 with matching sel 01 / 11; a dead cycle every time.
- Timeout (ARB_TIMEOUT_EN, HOLD_MAX=4), req=1111 constant. Expect 4 cycles gnt=0001, 1 cycle 0000, 4 cycles 0010, gap, 0100, gap, 1000, gap, 0001 again (ptr wrap).
- No timeout (macro undefined), req=1111 for 30 cycles -> gnt=0001 throughout. Drop req[0] -> gap, then gnt=0010.
- HOLD_MAX=1 with ARB_TIMEOUT_EN, req=0011 -> grants alternate 0001, 0000, 0010, 0000, ... The lone requester req=0001 holds indefinitely (others=0).
- Checker on every cycle: gnt one-hot-or-zero, gnt==(sel_en?1<<sel:0), busy==sel_en. A decoder-model compare of {Y3..Y0} against gnt must match.

Source files
------------

// File: rtl/decoder_rr_arbiter.sv
// Four-requester round-robin arbiter driving a 2-to-4 enabled decoder, with a forced dead cycle between grants.
// Optional owner preemption after HOLD_MAX contended cycles is built when ARB_TIMEOUT_EN is defined.
module decoder_rr_arbiter #(
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [1:0] sel,
  output logic       sel_en,
  output logic [3:0] gnt,
  output logic       busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam bit CFG_OK = (HOLD_MAX >= 1) && (HOLD_MAX <= 15) && ((2 ** CNT_W) > HOLD_MAX);

  if (!CFG_OK) begin : g_cfg_error
    $error("decoder_rr_arbiter: HOLD_MAX must be 1..15 and fit in CNT_W bits");
  end

  state_t     state_r, state_s;
  logic [1:0] ptr_r, ptr_s;
  logic [1:0] sel_r, sel_s;
  logic       sel_en_r, sel_en_s;
  logic [3:0] gnt_r, gnt_s;
  logic       busy_r;
  logic [1:0] pick_s;
  logic       others_s;
  logic       release_s;
  logic       preempt_s;

  // First requester at or after the pointer, wrapping modulo 4
  function automatic logic [1:0] rr_pick(input logic [3:0] req_v, input logic [1:0] ptr_v);
    logic [1:0] idx;
    rr_pick = ptr_v;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr_v + 2'(i);
      if (req_v[idx]) begin
        rr_pick = idx;
      end
    end
  endfunction

  // Model of the downstream 2-to-4 enabled decoder
  function automatic logic [3:0] dec2to4(input logic [1:0] a, input logic en);
    dec2to4 = en ? (4'b0001 << a) : 4'b0000;
  endfunction

  assign pick_s    = rr_pick(req, ptr_r);
  assign others_s  = |(req & ~gnt_r);
  assign release_s = ~req[sel_r];

`ifdef ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

  logic [CNT_W-1:0] hold_cnt_r, hold_cnt_s;

  assign preempt_s = others_s && (hold_cnt_r == HOLD_LAST);

  // Hold counter: counts contended cycles of the current owner, clears otherwise
  always_comb begin
    hold_cnt_s = hold_cnt_r;
    if ((state_r == GRANT) && (state_s == GRANT)) begin
      if (others_s && (hold_cnt_r != HOLD_LAST)) begin
        hold_cnt_s = hold_cnt_r + CNT_W'(1);
      end else if (others_s) begin
        hold_cnt_s = hold_cnt_r;
      end else begin
        hold_cnt_s = {CNT_W{1'b0}};
      end
    end else begin
      hold_cnt_s = {CNT_W{1'b0}};
    end
  end

  // Hold counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_r <= {CNT_W{1'b0}};
    end else begin
      hold_cnt_r <= hold_cnt_s;
    end
  end
`else
  assign preempt_s = 1'b0;
`endif

  // Next state and next registered outputs
  always_comb begin
    state_s  = state_r;
    sel_s    = sel_r;
    sel_en_s = 1'b0;
    ptr_s    = ptr_r;
    case (state_r)
      IDLE: begin
        if (|req) begin
          state_s  = GRANT;
          sel_s    = pick_s;
          sel_en_s = 1'b1;
          ptr_s    = pick_s + 2'd1;
        end else begin
          state_s  = IDLE;
        end
      end
      GRANT: begin
        // Leaving GRANT always passes through IDLE, giving the break-before-make gap
        if (release_s || preempt_s) begin
          state_s  = IDLE;
        end else begin
          state_s  = GRANT;
          sel_en_s = 1'b1;
        end
      end
      default: begin
        state_s  = IDLE;
      end
    endcase
    gnt_s = dec2to4(sel_s, sel_en_s);
  end

  // State, pointer and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      ptr_r    <= 2'd0;
      sel_r    <= 2'd0;
      sel_en_r <= 1'b0;
      gnt_r    <= 4'b0000;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      ptr_r    <= ptr_s;
      sel_r    <= sel_s;
      sel_en_r <= sel_en_s;
      gnt_r    <= gnt_s;
      busy_r   <= sel_en_s;
    end
  end

  assign sel    = sel_r;
  assign sel_en = sel_en_r;
  assign gnt    = gnt_r;
  assign busy   = busy_r;

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Directed table-driven bench for decoder_rr_arbiter; timeout scenarios run when ARB_TIMEOUT_EN is defined.
module tb_decoder_rr_arbiter;

`ifdef ARB_TIMEOUT_EN
  localparam int TB_HOLD = 4;
`else
  localparam int TB_HOLD = 8;
`endif

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [1:0] sel;
  logic       sel_en;
  logic [3:0] gnt;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       en;
    string      name;
  } vec_t;

  vec_t tv[11];

  decoder_rr_arbiter #(.HOLD_MAX(TB_HOLD), .CNT_W(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .sel    (sel),
    .sel_en (sel_en),
    .gnt    (gnt),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare outputs with expectations plus the per-cycle invariants and decoder model
  task automatic check(input string name, input logic [3:0] eg, input logic [1:0] es, input logic ee);
    logic [3:0] y;
    y = {sel_en & sel[1] & sel[0], sel_en & sel[1] & ~sel[0],
         sel_en & ~sel[1] & sel[0], sel_en & ~sel[1] & ~sel[0]};
    n_vec++;
    if (gnt !== eg || sel !== es || sel_en !== ee || busy !== ee) begin
      n_err++;
      $display("FAIL %s: got gnt=%b sel=%b sel_en=%b busy=%b, want gnt=%b sel=%b sel_en=%b busy=%b",
               name, gnt, sel, sel_en, busy, eg, es, ee, ee);
    end
    if (((gnt & (gnt - 4'd1)) !== 4'b0000) || (gnt !== y) || (busy !== sel_en)) begin
      n_err++;
      $display("FAIL %s_invariant: got gnt=%b sel=%b sel_en=%b busy=%b, want decoder Y=%b busy=sel_en",
               name, gnt, sel, sel_en, busy, y);
    end
  endtask

  task automatic apply(input logic [3:0] r);
    req = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;

    tv[0]  = '{4'b1010, 4'b0010, 2'b01, 1'b1, "rr_g1_a"};
    tv[1]  = '{4'b1010, 4'b0010, 2'b01, 1'b1, "rr_g1_b"};
    tv[2]  = '{4'b1000, 4'b0000, 2'b01, 1'b0, "rr_gap1"};
    tv[3]  = '{4'b1010, 4'b1000, 2'b11, 1'b1, "rr_g3_a"};
    tv[4]  = '{4'b1010, 4'b1000, 2'b11, 1'b1, "rr_g3_b"};
    tv[5]  = '{4'b0010, 4'b0000, 2'b11, 1'b0, "rr_gap2"};
    tv[6]  = '{4'b1010, 4'b0010, 2'b01, 1'b1, "rr_g1_again"};
    tv[7]  = '{4'b0000, 4'b0000, 2'b01, 1'b0, "release"};
    tv[8]  = '{4'b0000, 4'b0000, 2'b01, 1'b0, "idle_hold"};
    tv[9]  = '{4'b0100, 4'b0100, 2'b10, 1'b1, "g2_a"};
    tv[10] = '{4'b0100, 4'b0100, 2'b10, 1'b1, "g2_b"};

    repeat (2) @(negedge clk);
    check("reset", 4'b0000, 2'b00, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      apply(tv[i].req);
      check(tv[i].name, tv[i].gnt, tv[i].sel, tv[i].en);
    end

    // Asynchronous reset in the middle of a grant, between clock edges
    #2 rst_n = 1'b0;
    #1 check("async_reset", 4'b0000, 2'b00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    apply(4'b0001);
    check("post_reset", 4'b0001, 2'b00, 1'b1);

`ifndef ARB_TIMEOUT_EN
    for (int c = 0; c < 30; c++) begin
      apply(4'b1111);
      check("no_timeout_hold", 4'b0001, 2'b00, 1'b1);
    end
    apply(4'b1110);
    check("drop0_gap", 4'b0000, 2'b00, 1'b0);
    apply(4'b1110);
    check("drop0_next", 4'b0010, 2'b01, 1'b1);
`else
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    // Full contention: every owner is preempted after TB_HOLD cycles, order 0,1,2,3,0
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < ((k == 4) ? 1 : TB_HOLD); c++) begin
        apply(4'b1111);
        check("timeout_grant", 4'b0001 << (k % 4), 2'(k % 4), 1'b1);
      end
      if (k < 4) begin
        apply(4'b1111);
        check("timeout_gap", 4'b0000, 2'(k % 4), 1'b0);
      end
    end
    for (int c = 0; c < 10; c++) begin
      apply(4'b0001);
      check("lone_hold", 4'b0001, 2'b00, 1'b1);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
